// File: rtl/ur408_pkg.sv
// Shared UR408 encodings: execute-op kinds, writeback FSM states and GPR indices.
package ur408_pkg;

    localparam logic [1:0] KIND_ALU  = 2'd0;
    localparam logic [1:0] KIND_LOAD = 2'd1;
    localparam logic [1:0] KIND_CR   = 2'd2;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_LOAD  = 2'd1,
        WB_WRITE = 2'd2
    } wb_state_t;

    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    // Index of the highest set bit; callers only pass one-hot vectors.
    function automatic logic [2:0] onehot_idx(input logic [7:0] sel);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rd_decode.sv
// 3-to-8 one-hot GPR select with enable; cr_pair overrides to the r1:r0 pair.
module wb_rd_decode
    import ur408_pkg::*;
(
    input  logic       en,
    input  logic       cr_pair,
    input  logic [2:0] idx,
    output logic [7:0] sel
);

    always_comb begin
        sel = '0;
        if (en) begin
            if (cr_pair) begin
                sel[R0] = 1'b1;
                sel[R1] = 1'b1;
            end else begin
                case (idx)
                    R0: sel[R0] = 1'b1;
                    R1: sel[R1] = 1'b1;
                    R2: sel[R2] = 1'b1;
                    R3: sel[R3] = 1'b1;
                    R4: sel[R4] = 1'b1;
                    R5: sel[R5] = 1'b1;
                    R6: sel[R6] = 1'b1;
                    R7: sel[R7] = 1'b1;
                    default: sel = '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/wb_stage.sv
// UR408 writeback stage: registered GPR write pulses for ALU, CR-pair and load ops.
// Optional WB_FWD_EN adds combinational fwd_valid/fwd_idx/fwd_data bypass outputs.
module wb_stage
    import ur408_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    // Handshake: an op transfers on a rising edge where ex_valid and ex_ready are both high.
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [2:0]        ex_rd_idx,
    input  logic              ex_rd_we,
    input  logic [1:0]        ex_kind,
    input  logic [7:0]        ex_alu_data,
    input  logic [15:0]       ex_cr_data,
    input  logic [ADDR_W-1:0] ex_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              r0_write,
    output logic              r1_write,
    output logic              r2_write,
    output logic              r3_write,
    output logic              r4_write,
    output logic              r5_write,
    output logic              r6_write,
    output logic              r7_write,
    output logic              rd_r0_mux,
    output logic [7:0]        rd_data,
    output logic [15:0]       cr_data,
    output logic              bus_err,
    output logic              busy,
`ifdef WB_FWD_EN
    output logic              fwd_valid,
    output logic [2:0]        fwd_idx,
    output logic [7:0]        fwd_data,
`endif
    output logic [1:0]        dbg_state
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    wb_state_t         state, nxt_state;
    logic [7:0]        cnt, nxt_cnt;
    logic [2:0]        ld_idx, nxt_ld_idx;
    logic              ld_we, nxt_ld_we;
    logic [7:0]        wr_en, nxt_wr_en;
    logic              nxt_ex_ready, nxt_mem_req, nxt_mux, nxt_bus_err, nxt_busy;
    logic [ADDR_W-1:0] nxt_mem_addr;
    logic [7:0]        nxt_rd_data;
    logic [15:0]       nxt_cr_data;
    logic              dec_en, dec_cr;
    logic [2:0]        dec_idx;

    wb_rd_decode u_rd_decode (
        .en      (dec_en),
        .cr_pair (dec_cr),
        .idx     (dec_idx),
        .sel     (nxt_wr_en)
    );

    always_comb begin
        nxt_state    = state;
        nxt_cnt      = cnt;
        nxt_ld_idx   = ld_idx;
        nxt_ld_we    = ld_we;
        nxt_mem_req  = mem_req;
        nxt_mem_addr = mem_addr;
        nxt_rd_data  = rd_data;
        nxt_cr_data  = cr_data;
        nxt_mux      = 1'b0;
        nxt_bus_err  = 1'b0;
        dec_en       = 1'b0;
        dec_cr       = 1'b0;
        dec_idx      = ex_rd_idx;

        case (state)
            WB_IDLE: begin
                if (ex_valid && ex_ready) begin
                    if (ex_kind == KIND_LOAD) begin
                        nxt_state    = WB_LOAD;
                        nxt_mem_req  = 1'b1;
                        nxt_mem_addr = ex_addr;
                        nxt_ld_idx   = ex_rd_idx;
                        nxt_ld_we    = ex_rd_we;
                        nxt_cnt      = '0;
                    end else if (ex_kind == KIND_CR) begin
                        dec_en = ex_rd_we;
                        dec_cr = 1'b1;
                        if (ex_rd_we) begin
                            nxt_cr_data = ex_cr_data;
                            nxt_mux     = 1'b1;
                        end
                    end else begin
                        // Reserved kind retires as an ALU op.
                        dec_en = ex_rd_we;
                        if (ex_rd_we) nxt_rd_data = ex_alu_data;
                    end
                end
            end
            WB_LOAD: begin
                // An ack on the expiry cycle still completes the load.
                if (mem_ack) begin
                    nxt_state   = WB_WRITE;
                    nxt_mem_req = 1'b0;
                    dec_en      = ld_we;
                    dec_idx     = ld_idx;
                    nxt_rd_data = mem_rdata;
                end else if (cnt >= TO_LAST) begin
                    nxt_state   = WB_IDLE;
                    nxt_mem_req = 1'b0;
                    nxt_bus_err = 1'b1;
                end else if (cnt != 8'hFF) begin
                    nxt_cnt = cnt + 8'd1;
                end
            end
            WB_WRITE: nxt_state = WB_IDLE;
            default:  nxt_state = WB_IDLE;
        endcase

        nxt_ex_ready = (nxt_state == WB_IDLE);
        nxt_busy     = (nxt_state == WB_LOAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WB_IDLE;
            cnt       <= '0;
            ld_idx    <= '0;
            ld_we     <= 1'b0;
            wr_en     <= '0;
            ex_ready  <= 1'b1;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            rd_r0_mux <= 1'b0;
            rd_data   <= '0;
            cr_data   <= '0;
            bus_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            ld_idx    <= nxt_ld_idx;
            ld_we     <= nxt_ld_we;
            wr_en     <= nxt_wr_en;
            ex_ready  <= nxt_ex_ready;
            mem_req   <= nxt_mem_req;
            mem_addr  <= nxt_mem_addr;
            rd_r0_mux <= nxt_mux;
            rd_data   <= nxt_rd_data;
            cr_data   <= nxt_cr_data;
            bus_err   <= nxt_bus_err;
            busy      <= nxt_busy;
        end
    end

    assign r0_write  = wr_en[0];
    assign r1_write  = wr_en[1];
    assign r2_write  = wr_en[2];
    assign r3_write  = wr_en[3];
    assign r4_write  = wr_en[4];
    assign r5_write  = wr_en[5];
    assign r6_write  = wr_en[6];
    assign r7_write  = wr_en[7];
    assign dbg_state = state;

`ifdef WB_FWD_EN
    // CR pair writes are not forwardable as a single byte.
    assign fwd_valid = (wr_en != '0) && !rd_r0_mux;
    assign fwd_idx   = onehot_idx(wr_en);
    assign fwd_data  = rd_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboarded bench for wb_stage: directed cases plus random ops against a reference model.
module tb_wb_stage;
    import ur408_pkg::*;

    localparam int T  = 16;
    localparam int AW = 16;
    localparam int W  = 66;

    logic          clk, rst;
    logic          ex_valid, ex_ready, ex_rd_we;
    logic [2:0]    ex_rd_idx;
    logic [1:0]    ex_kind;
    logic [7:0]    ex_alu_data;
    logic [15:0]   ex_cr_data;
    logic [AW-1:0] ex_addr;
    logic          mem_req, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          r0_write, r1_write, r2_write, r3_write;
    logic          r4_write, r5_write, r6_write, r7_write;
    logic          rd_r0_mux, bus_err, busy;
    logic [7:0]    rd_data;
    logic [15:0]   cr_data;
    logic [1:0]    dbg_state;
`ifdef WB_FWD_EN
    logic          fwd_valid;
    logic [2:0]    fwd_idx;
    logic [7:0]    fwd_data;
`endif

    wb_stage #(.TIMEOUT_CYCLES(T), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd_idx(ex_rd_idx), .ex_rd_we(ex_rd_we),
        .ex_kind(ex_kind), .ex_alu_data(ex_alu_data), .ex_cr_data(ex_cr_data), .ex_addr(ex_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .r0_write(r0_write), .r1_write(r1_write), .r2_write(r2_write), .r3_write(r3_write),
        .r4_write(r4_write), .r5_write(r5_write), .r6_write(r6_write), .r7_write(r7_write),
        .rd_r0_mux(rd_r0_mux), .rd_data(rd_data), .cr_data(cr_data),
        .bus_err(bus_err), .busy(busy),
`ifdef WB_FWD_EN
        .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    // Event: {bus_err, write vector, rd_r0_mux, rd_data, cr_data, cycle stamp}
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] mk_ev(input logic e, input logic [7:0] wr, input logic m,
                                           input logic [7:0] rd, input logic [15:0] cr,
                                           input logic [31:0] st);
        return {e, wr, m, rd, cr, st};
    endfunction

    // Memory contents seen by loads.
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h51;
    endfunction

    function automatic logic [7:0] gpr_sel(input logic [2:0] n);
        logic [7:0] one;
        one = 8'd1;
        return one << n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_step();
        logic [7:0]   wr;
        logic [W-1:0] e;
        @(negedge clk);
        wr = {r7_write, r6_write, r5_write, r4_write, r3_write, r2_write, r1_write, r0_write};
        while (exp_q.size() > 0 && exp_q[0][31:0] < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse actual=none required_wr=%b err=%b at cycle %0d",
                     e[64:57], e[65], e[31:0]);
        end
        if (rst && (wr != 8'h00 || bus_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual_wr=%b bus_err=%b required=none (cycle %0d)",
                         wr, bus_err, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("ev_stamp", 64'(cyc), 64'(e[31:0]));
                chk("ev_bus_err", 64'(bus_err), 64'(e[65]));
                chk("ev_wr_vec", 64'(wr), 64'(e[64:57]));
                chk("ev_r0_mux", 64'(rd_r0_mux), 64'(e[56]));
                if (e[56]) chk("ev_cr_data", 64'(cr_data), 64'(e[31+16:32]));
                else if (e[64:57] != 8'h00) chk("ev_rd_data", 64'(rd_data), 64'(e[55:48]));
            end
        end
    endtask

    // ---------------- driver ----------------
    // d: cycle of mem_req in which mem_ack is given; d > T means no ack before timeout,
    // followed by a stray ack (d - T) cycles after the timeout.
    task automatic drive_op(input logic [1:0] kind, input logic [2:0] idx, input logic we,
                            input logic [7:0] alu, input logic [15:0] cr, input logic [15:0] addr,
                            input int d);
        int guard;
        logic [7:0] v;
        @(negedge clk);
        guard = 0;
        while (!ex_ready && guard < 50) begin
            ex_valid = 1'b0;
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", 64'(ex_ready), 64'd1);
        if (!ex_ready) return;
        ex_valid = 1'b1; ex_kind = kind; ex_rd_idx = idx; ex_rd_we = we;
        ex_alu_data = alu; ex_cr_data = cr; ex_addr = addr;
        @(posedge clk); #1;
        if (kind == KIND_CR) begin
            if (we) exp_q.push_back(mk_ev(1'b0, 8'b0000_0011, 1'b1, 8'h00, cr, cyc));
        end else if (kind != KIND_LOAD) begin
            if (we) exp_q.push_back(mk_ev(1'b0, gpr_sel(idx), 1'b0, alu, 16'h0, cyc));
        end else begin
            ex_valid = 1'b0;
            v = mem_val(addr);
            for (int c = 1; c <= T; c++) begin
                @(negedge clk);
                chk("ld_mem_req", 64'(mem_req), 64'd1);
                chk("ld_mem_addr", 64'(mem_addr), 64'(addr));
                chk("ld_ex_ready", 64'(ex_ready), 64'd0);
                chk("ld_busy", 64'(busy), 64'd1);
                if (c == d) begin
                    mem_ack = 1'b1; mem_rdata = v;
                    @(posedge clk); #1;
                    mem_ack = 1'b0; mem_rdata = 8'($urandom);
                    if (we) exp_q.push_back(mk_ev(1'b0, gpr_sel(idx), 1'b0, v, 16'h0, cyc));
                    @(negedge clk);
                    chk("wr_mem_req", 64'(mem_req), 64'd0);
                    chk("wr_ex_ready", 64'(ex_ready), 64'd0);
                    chk("wr_busy", 64'(busy), 64'd0);
                    break;
                end
                if (c == T) begin
                    @(posedge clk); #1;
                    exp_q.push_back(mk_ev(1'b1, 8'h00, 1'b0, 8'h00, 16'h0, cyc));
                    @(negedge clk);
                    chk("to_mem_req", 64'(mem_req), 64'd0);
                    chk("to_busy", 64'(busy), 64'd0);
                    repeat (d - T - 1) @(negedge clk);
                    mem_ack = 1'b1; mem_rdata = 8'($urandom);
                    @(posedge clk); #1;
                    mem_ack = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        ex_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic summary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int unsigned c1;
        rst = 1'b0; ex_valid = 1'b0; ex_rd_idx = '0; ex_rd_we = 1'b0; ex_kind = '0;
        ex_alu_data = '0; ex_cr_data = '0; ex_addr = '0; mem_ack = 1'b0; mem_rdata = '0;

        fork
            forever monitor_step();
            begin
                #400000;
                checks++;
                errors++;
                $display("FAIL watchdog time limit reached");
                summary();
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_wr_vec", 64'({r7_write, r6_write, r5_write, r4_write,
                               r3_write, r2_write, r1_write, r0_write}), 64'd0);
        chk("rst_outputs", 64'({rd_r0_mux, rd_data, cr_data, bus_err, busy}), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_ex_ready", 64'(ex_ready), 64'd1);
        chk("rel_state", 64'(dbg_state), 64'(WB_IDLE));

        // Back-to-back ALU writes
        drive_op(KIND_ALU, 3'd3, 1'b1, 8'h5A, 16'h0, 16'h0, 0);
        c1 = cyc;
        drive_op(KIND_ALU, 3'd7, 1'b1, 8'hC3, 16'h0, 16'h0, 0);
        chk("b2b_alu_accept", 64'(cyc - c1), 64'd1);
        idle(2);

        // CR pair write
        drive_op(KIND_CR, 3'd5, 1'b1, 8'h00, 16'hBEEF, 16'h0, 0);
        idle(2);

        // Load with ack in the third request cycle
        drive_op(KIND_LOAD, 3'd5, 1'b1, 8'h00, 16'h0, 16'h1234, 3);
        @(negedge clk);
        chk("post_load_ready", 64'(ex_ready), 64'd1);
        idle(1);

        // Load timeout with a stray late ack, then ack exactly on the expiry cycle
        drive_op(KIND_LOAD, 3'd2, 1'b1, 8'h00, 16'h0, 16'h4321, T + 3);
        idle(2);
        drive_op(KIND_LOAD, 3'd6, 1'b1, 8'h00, 16'h0, 16'hA0F0, T);
        idle(2);

        // Silent retire followed immediately by another op; reserved kind acts as ALU
        drive_op(KIND_ALU, 3'd4, 1'b0, 8'h99, 16'h0, 16'h0, 0);
        c1 = cyc;
        drive_op(2'd3, 3'd1, 1'b1, 8'h3E, 16'h0, 16'h0, 0);
        chk("b2b_silent_accept", 64'(cyc - c1), 64'd1);
        idle(2);

        // Reset in the middle of a load, then a late ack after release
        @(negedge clk);
        ex_valid = 1'b1; ex_kind = KIND_LOAD; ex_rd_idx = 3'd1; ex_rd_we = 1'b1; ex_addr = 16'h0F0F;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_state", 64'(dbg_state), 64'(WB_IDLE));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (T + 2) @(negedge clk);
        chk("late_ack_mem_req", 64'(mem_req), 64'd0);
        chk("late_ack_ready", 64'(ex_ready), 64'd1);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            drive_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 7) != 0), 8'($urandom), 16'($urandom),
                     16'($urandom), $urandom_range(1, T + 2));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(T + 4);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        summary();
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage of the UR408 core, directly upstream of the general-purpose register file. It accepts retired ALU results, 16-bit control-register (CR) transfers and byte loads from the execute stage. Loads are run over a req/ack data-memory handshake. The stage drives the register file's one-hot write enables (r0_write..r7_write), rd_data, rd_r0_mux and cr_data as registered, single-cycle write pulses.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a load waits for mem_ack before abort (range 2..255)
ADDR_W, 16, data-memory address width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
ex_valid  in  1  execute stage presents an op
ex_ready  out  1  stage can accept an op this cycle
ex_rd_idx  in  3  destination register index 0..7
ex_rd_we  in  1  op writes a GPR (0 = retire without write)
ex_kind  in  2  0 ALU, 1 LOAD, 2 CR pair write, 3 reserved (treated as ALU)
ex_alu_data  in  8  ALU result
ex_cr_data  in  16  CR value for the r1:r0 pair
ex_addr  in  ADDR_W  load address
mem_req  out  1  load request, held until ack
mem_addr  out  ADDR_W  load address
mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle
mem_rdata  in  8  load data
r0_write..r7_write  out  1 each  one-hot GPR write enables
rd_r0_mux  out  1  1 selects cr_data for r0/r1
rd_data  out  8  byte write data
cr_data  out  16  CR pair write data
bus_err  out  1  one-cycle pulse on load timeout
busy  out  1  high while a load is outstanding (hazard stall for decode)

Behaviour:
- All outputs are registered. Reset values: all zero; ex_ready = 1 and state = IDLE on release of reset.
- FSM states: IDLE, LOAD, WRITE.
- IDLE:
  - ex_ready = 1.
  - Accept on ex_valid & ex_ready.
  - ALU with ex_rd_we: the next cycle drives exactly one rN_write = 1 (N = ex_rd_idx), rd_data = ex_alu_data, rd_r0_mux = 0. The FSM stays in IDLE, so back-to-back ALU ops retire one per cycle.
  - ALU with ex_rd_we = 0: retires silently; no write pulse.
  - CR with ex_rd_we: the next cycle drives r0_write = r1_write = 1, rd_r0_mux = 1, cr_data = ex_cr_data. ex_rd_idx is ignored.
  - LOAD: go to LOAD. mem_req = 1 and mem_addr = ex_addr from the next cycle.
- LOAD:
  - ex_ready = 0, busy = 1. mem_req and mem_addr are held stable.
  - mem_ack = 1: capture mem_rdata, drop mem_req next cycle, go to WRITE.
  - Timeout counter reaches TIMEOUT_CYCLES without ack: drop mem_req, pulse bus_err for one cycle, return to IDLE with no GPR write.
  - mem_ack in the same cycle as timeout expiry: ack wins, no bus_err.
- WRITE:
  - One cycle with rN_write = ex_rd_we, rd_data = captured byte, rd_r0_mux = 0.
  - ex_ready = 0 in this cycle; return to IDLE.
  - Load-to-GPR latency: ack edge + 1 cycle pulse; the GPR updates at the following edge.
- Write pulses last exactly one cycle. The rN_write vector is never multi-hot, except r0+r1 for a CR op.
- The timeout counter is 8 bits, clears on entry to LOAD, and saturates (no wrap).
- Reset asserted mid-load: immediate return to IDLE. mem_req, all write enables and bus_err go to 0. The pending load is discarded; a late mem_ack after reset is ignored.
- mem_ack while not in LOAD: ignored.

Optional Feature:
WB_FWD_EN
- Defined: adds outputs fwd_valid (1), fwd_idx (3) and fwd_data (8). They are combinational copies of the write pulse in progress: valid whenever any single rN_write is high, idx = N, data = rd_data. They let decode bypass the register file. A CR pair write sets fwd_valid = 0.
- Undefined: the ports are absent, and decode relies on busy plus one stall cycle after a write.

Decomposition:
- Shared package ur408_pkg holds:
  - the ex_kind encodings (KIND_ALU, KIND_LOAD, KIND_CR);
  - the FSM state encodings (WB_IDLE, WB_LOAD, WB_WRITE);
  - GPR index constants R0..R7.
- One sub-module, wb_rd_decode: 3-to-8 one-hot decoder with enable, plus the CR-pair override. It is shared with decode's ds1/ds2 select generation.

Test Plan:
- ALU idx 3 data 0x5A, then idx 7 data 0xC3, back to back -> r3_write pulse with rd_data 0x5A, next cycle r7_write with 0xC3; never two enables high at once.
- CR op, ex_cr_data 0xBEEF -> one cycle with r0_write = r1_write = 1, rd_r0_mux = 1, cr_data 0xBEEF.
- LOAD addr 0x1234 idx 5, ack after 3 cycles with 0x77 -> mem_req held 3 cycles at 0x1234, then r5_write with 0x77; ex_ready low throughout.
- LOAD with no ack, TIMEOUT_CYCLES = 16 -> mem_req drops after 16 cycles, bus_err single pulse, no write enable asserted.
- rst low mid-LOAD, then late mem_ack after release -> outputs zero immediately; no write pulse after release.
- ALU op with ex_rd_we = 0 -> no rN_write pulse; the next op is accepted the following cycle.
